// File: rtl/sms23_scan_pkg.sv
// Shared constants, FSM state type and helpers for the S-box DDT scanner.
package sms23_scan_pkg;

    localparam int SB_N    = 6;
    localparam int SB_SIZE = 64;
    localparam int CNT_W   = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_t;

    // A map of 2^N outputs is a bijection exactly when every output value was hit.
    function automatic logic all_seen(input logic [SB_SIZE-1:0] seen);
        return &seen;
    endfunction

endpackage

// File: rtl/ddt_counter_bank.sv
// One DDT row of 7-bit occurrence counters with single-index read-modify-write.
module ddt_counter_bank
    import sms23_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [SB_N-1:0]  idx,
    output logic [CNT_W-1:0] inc_val
);

    logic [CNT_W-1:0] cnt_q [SB_SIZE];
    logic [CNT_W-1:0] cnt_d [SB_SIZE];

    // Next counter contents: clear-all wins over the single increment.
    always_comb begin
        cnt_d   = cnt_q;
        inc_val = cnt_q[idx] + 7'd1;
        if (clr) begin
            for (int i = 0; i < SB_SIZE; i++) begin
                cnt_d[i] = 7'd0;
            end
        end else if (inc) begin
            cnt_d[idx] = inc_val;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SB_SIZE; i++) begin
                cnt_q[i] <= 7'd0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sms23_ddt_scanner.sv
// Sweeps an attached 6-bit S-box, checks bijectivity and finds its
// differential uniformity plus the first (alpha, beta) pair reaching it.
module sms23_ddt_scanner
    import sms23_scan_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] sbox_x,
    input  logic [N-1:0] sbox_y,
    output logic         busy,
    output logic         done,
    output logic         is_perm,
    output logic [6:0]   du,
    output logic [N-1:0] du_alpha,
    output logic [N-1:0] du_beta
);

    if (N != SB_N) begin : g_bad_width
        $error("sms23_ddt_scanner supports only N = 6");
    end

    scan_state_t        state_q, state_d;
    logic [SB_N-1:0]    idx_q, idx_d;
    logic [SB_N-1:0]    alpha_q, alpha_d;
    logic [SB_N-1:0]    table_q [SB_SIZE];
    logic [SB_N-1:0]    table_d [SB_SIZE];
    logic [SB_SIZE-1:0] seen_q, seen_d;
    logic               is_perm_q, is_perm_d;
    logic [CNT_W-1:0]   du_q, du_d;
    logic [SB_N-1:0]    du_alpha_q, du_alpha_d;
    logic [SB_N-1:0]    du_beta_q, du_beta_d;

    logic [SB_N-1:0]    beta_s;
    logic [CNT_W-1:0]   inc_val_s;
    logic               cnt_clr_s;
    logic               cnt_inc_s;

    assign beta_s = table_q[idx_q] ^ table_q[idx_q ^ alpha_q];

    ddt_counter_bank u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr_s),
        .inc     (cnt_inc_s),
        .idx     (beta_s),
        .inc_val (inc_val_s)
    );

    // FSM next-state, table fill, and running-maximum tracking.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        alpha_d    = alpha_q;
        table_d    = table_q;
        seen_d     = seen_q;
        is_perm_d  = is_perm_q;
        du_d       = du_q;
        du_alpha_d = du_alpha_q;
        du_beta_d  = du_beta_q;
        cnt_clr_s  = 1'b0;
        cnt_inc_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_FILL;
                    idx_d      = 6'd0;
                    alpha_d    = 6'd0;
                    seen_d     = 64'd0;
                    is_perm_d  = 1'b0;
                    du_d       = 7'd0;
                    du_alpha_d = 6'd0;
                    du_beta_d  = 6'd0;
                    cnt_clr_s  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FILL: begin
                table_d[idx_q] = sbox_y;
                seen_d[sbox_y] = 1'b1;
                idx_d          = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    is_perm_d = all_seen(seen_d);
                    alpha_d   = 6'd1;
                    state_d   = ST_CLEAR;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_CLEAR: begin
                cnt_clr_s = 1'b1;
                idx_d     = 6'd0;
                state_d   = ST_SCAN;
            end
            ST_SCAN: begin
                cnt_inc_s = 1'b1;
                idx_d     = idx_q + 6'd1;
                // Strict compare keeps the earliest pair on ties.
                if (inc_val_s > du_q) begin
                    du_d       = inc_val_s;
                    du_alpha_d = alpha_q;
                    du_beta_d  = beta_s;
                end else begin
                    du_d = du_q;
                end
                if (idx_q == 6'd63) begin
                    if (alpha_q == 6'd63) begin
                        state_d = ST_DONE;
                    end else begin
                        alpha_d = alpha_q + 6'd1;
                        state_d = ST_CLEAR;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, table and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 6'd0;
            alpha_q    <= 6'd0;
            seen_q     <= 64'd0;
            is_perm_q  <= 1'b0;
            du_q       <= 7'd0;
            du_alpha_q <= 6'd0;
            du_beta_q  <= 6'd0;
            for (int i = 0; i < SB_SIZE; i++) begin
                table_q[i] <= 6'd0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            alpha_q    <= alpha_d;
            seen_q     <= seen_d;
            is_perm_q  <= is_perm_d;
            du_q       <= du_d;
            du_alpha_q <= du_alpha_d;
            du_beta_q  <= du_beta_d;
            table_q    <= table_d;
        end
    end

    assign sbox_x   = (state_q == ST_FILL) ? idx_q : 6'd0;
    assign busy     = (state_q == ST_FILL) || (state_q == ST_CLEAR) || (state_q == ST_SCAN);
    assign done     = (state_q == ST_DONE);
    assign is_perm  = is_perm_q;
    assign du       = du_q;
    assign du_alpha = du_alpha_q;
    assign du_beta  = du_beta_q;

endmodule
